// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the CPU and the loader.
// It allows one transaction in flight and holds the CPU with a stall while its access is pending.
module mem_bus_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  // Handshake: a requester raises req with we/addr/wdata and holds all of them until it
  // sees a one-cycle gnt. Read data returns later on a one-cycle rvalid pulse.
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_LDR = 1'b1;
  localparam logic [2:0] LAT     = 3'(MEM_LAT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          ldr_gnt_q, ldr_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          ldr_rvalid_q, ldr_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

  logic          cpu_elig;
  logic          ldr_elig;
  logic          pick_ldr;
  logic          cpu_active;

  assign cpu_elig = cpu_req && !ldr_lock;
  assign ldr_elig = ldr_req;
  // On a tie the requester that was not served last wins.
  assign pick_ldr = ldr_elig && (!cpu_elig || (last_q == OWN_CPU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_q       <= OWN_LDR;
      we_q         <= 1'b0;
      cnt_q        <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    case (state_q)
      S_IDLE: begin
        // The GRANT-cycle strobes are computed here so that mem_* and gnt come straight from flops.
        if (cpu_elig || ldr_elig) begin
          owner_d     = pick_ldr;
          last_d      = pick_ldr;
          we_d        = pick_ldr ? ldr_we : cpu_we;
          mem_addr_d  = pick_ldr ? ldr_addr : cpu_addr;
          mem_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          mem_wr_d    = we_d;
          mem_rd_d    = !we_d;
          cpu_gnt_d   = !pick_ldr;
          ldr_gnt_d   = pick_ldr;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = LAT;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 3'd1) begin
          if (owner_q == OWN_LDR) begin
            ldr_rdata_d  = mem_rdata;
            ldr_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = mem_rdata;
            cpu_rvalid_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A CPU write releases the stall in its grant cycle; a CPU read holds it until RESP.
  assign cpu_active = (state_q != S_IDLE) && (owner_q == OWN_CPU);
  assign cpu_stall  = cpu_active ? (((state_q == S_GRANT) && !we_q) || (state_q == S_RWAIT))
                                 : cpu_req;

  assign cpu_gnt    = cpu_gnt_q;
  assign ldr_gnt    = ldr_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with a behavioural memory,
// a per-requester scoreboard and directed cycle checks.
module tb_mem_bus_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (MEM_LAT = 1) ----------------
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_gnt, ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr;
  logic [1:0]    dbg_state;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (MEM_LAT = 3) ----------------
  logic          cpu_req_3 = 1'b0, cpu_we_3 = 1'b0;
  logic [AW-1:0] cpu_addr_3 = '0;
  logic [DW-1:0] cpu_wdata_3 = '0;
  logic          cpu_gnt_3, cpu_rvalid_3, cpu_stall_3;
  logic [DW-1:0] cpu_rdata_3;
  logic          ldr_req_3 = 1'b0, ldr_we_3 = 1'b0, ldr_lock_3 = 1'b0;
  logic [AW-1:0] ldr_addr_3 = '0;
  logic [DW-1:0] ldr_wdata_3 = '0;
  logic          ldr_gnt_3, ldr_rvalid_3;
  logic [DW-1:0] ldr_rdata_3;
  logic [AW-1:0] mem_addr_3;
  logic [DW-1:0] mem_wdata_3, mem_rdata_3;
  logic          mem_rd_3, mem_wr_3;
  logic [1:0]    dbg_state_3;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_gnt(cpu_gnt_3), .cpu_rdata(cpu_rdata_3), .cpu_rvalid(cpu_rvalid_3), .cpu_stall(cpu_stall_3),
    .ldr_req(ldr_req_3), .ldr_we(ldr_we_3), .ldr_addr(ldr_addr_3), .ldr_wdata(ldr_wdata_3),
    .ldr_lock(ldr_lock_3), .ldr_gnt(ldr_gnt_3), .ldr_rdata(ldr_rdata_3), .ldr_rvalid(ldr_rvalid_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rd(mem_rd_3), .mem_wr(mem_wr_3),
    .mem_rdata(mem_rdata_3), .dbg_state(dbg_state_3)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // ---------------- memory models ----------------
  // Read data is driven only in its valid cycle; otherwise 8'hEE so that a mistimed capture shows up.
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] rd1_data;
  logic          rd1_vld;
  bit            mem1_init = 1'b0;
  always @(posedge clk) begin
    if (!mem1_init) begin
      for (int i = 0; i < 32; i++) mem1[i] = init_val(i);
      mem1_init = 1'b1;
    end
    if (mem_wr) mem1[mem_addr] = mem_wdata;
    rd1_vld  <= mem_rd;
    rd1_data <= mem1[mem_addr];
  end
  assign mem_rdata = rd1_vld ? rd1_data : 8'hEE;

  logic [DW-1:0] mem3 [32];
  logic [DW-1:0] p3_data [3];
  logic [2:0]    p3_vld;
  bit            mem3_init = 1'b0;
  always @(posedge clk) begin
    if (!mem3_init) begin
      for (int i = 0; i < 32; i++) mem3[i] = init_val(i);
      mem3_init = 1'b1;
    end
    if (mem_wr_3) mem3[mem_addr_3] = mem_wdata_3;
    p3_vld     <= {p3_vld[1:0], mem_rd_3};
    p3_data[0] <= mem3[mem_addr_3];
    p3_data[1] <= p3_data[0];
    p3_data[2] <= p3_data[1];
  end
  assign mem_rdata_3 = p3_vld[2] ? p3_data[2] : 8'hEE;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]    ref_mem [32];
  logic [DW-1:0]    cpu_q[$];
  logic [DW-1:0]    ldr_q[$];
  logic [AW+DW-1:0] cpu_wr_q[$];
  logic [AW+DW-1:0] ldr_wr_q[$];
  logic             gnt_who_q[$];
  int               gnt_cyc_q[$];
  int               cpu_rv_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_gnt && ldr_gnt) chk("dual_gnt", 32'(1), 32'(0));
      if (cpu_rvalid && ldr_rvalid) chk("dual_rvalid", 32'(1), 32'(0));
      if (cpu_gnt || ldr_gnt) begin
        gnt_who_q.push_back(ldr_gnt);
        gnt_cyc_q.push_back(cyc);
      end
      if (mem_wr) begin
        if (ldr_gnt) begin
          if (ldr_wr_q.size() == 0) chk("ldr_wr_unexp", 32'(1), 32'(0));
          else chk("ldr_wr", 32'({mem_addr, mem_wdata}), 32'(ldr_wr_q.pop_front()));
        end else if (cpu_gnt) begin
          if (cpu_wr_q.size() == 0) chk("cpu_wr_unexp", 32'(1), 32'(0));
          else chk("cpu_wr", 32'({mem_addr, mem_wdata}), 32'(cpu_wr_q.pop_front()));
        end else begin
          chk("wr_no_gnt", 32'(1), 32'(0));
        end
      end
      if (cpu_rvalid) begin
        cpu_rv_cnt++;
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexp", 32'(1), 32'(0));
        else chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (ldr_rvalid) begin
        if (ldr_q.size() == 0) chk("ldr_rvalid_unexp", 32'(1), 32'(0));
        else chk("ldr_rdata", 32'(ldr_rdata), 32'(ldr_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    if (we) begin
      ref_mem[a] = d;
      cpu_wr_q.push_back({a, d});
    end else begin
      cpu_q.push_back(ref_mem[a]);
    end
    do begin @(posedge clk); #1; n++; end while (!cpu_gnt && n < 100);
    chk("cpu_gnt_wait", 32'(cpu_gnt), 32'(1));
    cpu_req = 1'b0;
  endtask

  task automatic ldr_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
    if (we) begin
      ref_mem[a] = d;
      ldr_wr_q.push_back({a, d});
    end else begin
      ldr_q.push_back(ref_mem[a]);
    end
    do begin @(posedge clk); #1; n++; end while (!ldr_gnt && n < 100);
    chk("ldr_gnt_wait", 32'(ldr_gnt), 32'(1));
    ldr_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((dbg_state != 2'd0 || cpu_q.size() != 0 || ldr_q.size() != 0 ||
            cpu_wr_q.size() != 0 || ldr_wr_q.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(n < 50), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'(0));
    chk("rst_ldr_gnt", 32'(ldr_gnt), 32'(0));
    chk("rst_mem_rd", 32'(mem_rd), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'(0));
    chk("rst_stall", 32'(cpu_stall), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write alone
    cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    ref_mem[5] = 8'h3C;
    cpu_wr_q.push_back({5'h05, 8'h3C});
    #1;
    chk("wr_c0_stall", 32'(cpu_stall), 32'(1));
    chk("wr_c0_gnt", 32'(cpu_gnt), 32'(0));
    @(posedge clk); #1;
    chk("wr_c1_gnt", 32'(cpu_gnt), 32'(1));
    chk("wr_c1_mem_wr", 32'(mem_wr), 32'(1));
    chk("wr_c1_mem_rd", 32'(mem_rd), 32'(0));
    chk("wr_c1_addr", 32'(mem_addr), 32'h05);
    chk("wr_c1_wdata", 32'(mem_wdata), 32'h3C);
    chk("wr_c1_stall", 32'(cpu_stall), 32'(0));
    cpu_req = 1'b0;
    drain();

    // CPU read of 1F after the loader stores A5 there
    ldr_xfer(1'b1, 5'h1F, 8'hA5);
    drain();
    cpu_we = 1'b0; cpu_addr = 5'h1F; cpu_req = 1'b1;
    cpu_q.push_back(8'hA5);
    #1;
    chk("rd_c0_stall", 32'(cpu_stall), 32'(1));
    @(posedge clk); #1;
    chk("rd_c1_gnt", 32'(cpu_gnt), 32'(1));
    chk("rd_c1_mem_rd", 32'(mem_rd), 32'(1));
    chk("rd_c1_addr", 32'(mem_addr), 32'h1F);
    chk("rd_c1_stall", 32'(cpu_stall), 32'(1));
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_c2_stall", 32'(cpu_stall), 32'(1));
    chk("rd_c2_rvalid", 32'(cpu_rvalid), 32'(0));
    chk("rd_c2_mem_rd", 32'(mem_rd), 32'(0));
    @(posedge clk); #1;
    chk("rd_c3_rvalid", 32'(cpu_rvalid), 32'(1));
    chk("rd_c3_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_c3_stall", 32'(cpu_stall), 32'(0));
    drain();
    ldr_xfer(1'b0, 5'h05, 8'h00);
    drain();

    // contention: both write continuously, loader served last so CPU goes first
    gnt_who_q.delete(); gnt_cyc_q.delete();
    fork
      for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 5'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) ldr_xfer(1'b1, 5'($urandom_range(16, 31)), 8'($urandom_range(0, 255)));
    join
    drain();
    chk("cont_ngnt", 32'(gnt_who_q.size()), 32'(8));
    for (int i = 0; i < gnt_who_q.size(); i++) chk("cont_order", 32'(gnt_who_q[i]), 32'(i % 2));
    for (int i = 1; i < gnt_cyc_q.size(); i++) chk("cont_gap", 32'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 32'(2));

    // read every word back, alternating requesters
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) ldr_xfer(1'b0, 5'(i), 8'h00);
      else cpu_xfer(1'b0, 5'(i), 8'h00);
    end
    drain();

    // ldr_lock: only the loader is served until lock drops, then CPU wins the next tie
    ldr_lock = 1'b1;
    gnt_who_q.delete(); gnt_cyc_q.delete();
    fork
      cpu_xfer(1'b0, 5'd3, 8'h00);
      begin
        for (int i = 0; i < 3; i++) begin
          ldr_xfer(1'b0, 5'(20 + i), 8'h00);
          chk("lock_stall", 32'(cpu_stall), 32'(1));
          chk("lock_cpu_gnt", 32'(cpu_gnt), 32'(0));
        end
        ldr_lock = 1'b0;
        ldr_xfer(1'b0, 5'd24, 8'h00);
      end
    join
    drain();
    chk("lock_ngnt", 32'(gnt_who_q.size()), 32'(5));
    for (int i = 0; i < gnt_who_q.size(); i++) chk("lock_order", 32'(gnt_who_q[i]), 32'(i != 3));

    // MEM_LAT=3 loader read: rvalid exactly 5 cycles after the request is seen
    ldr_we_3 = 1'b0; ldr_addr_3 = 5'h0A; ldr_req_3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("lat3_gnt", 32'(ldr_gnt_3), 32'(1));
        ldr_req_3 = 1'b0;
      end
      chk("lat3_rvalid", 32'(ldr_rvalid_3), 32'(k == 5));
      chk("lat3_cpu_rvalid", 32'(cpu_rvalid_3), 32'(0));
    end
    chk("lat3_rdata", 32'(ldr_rdata_3), 32'(init_val(10)));

    // reset in the middle of a CPU read
    cpu_we = 1'b0; cpu_addr = 5'h07; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("mid_gnt", 32'(cpu_gnt), 32'(1));
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("mid_rwait", 32'(dbg_state), 32'(2));
    rv0 = cpu_rv_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({mem_rd, mem_wr, cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid}), 32'(0));
    chk("mid_rst_addr", 32'(mem_addr), 32'(0));
    chk("mid_rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'(0));
    chk("mid_rst_state", 32'(dbg_state), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_rvalid", 32'(cpu_rv_cnt - rv0), 32'(0));
    gnt_who_q.delete(); gnt_cyc_q.delete();
    fork
      cpu_xfer(1'b1, 5'h02, 8'h11);
      ldr_xfer(1'b1, 5'h12, 8'h22);
    join
    drain();
    chk("post_rst_ngnt", 32'(gnt_who_q.size()), 32'(2));
    if (gnt_who_q.size() > 0) chk("post_rst_first", 32'(gnt_who_q[0]), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
